// File: rtl/rr_mux8_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | rr_mux8_arbiter_pkg : shared types and constants for the arbiter     |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package rr_mux8_arbiter_pkg;

  localparam int c_num_req = 8;
  localparam int c_sel_w   = 3;
  localparam int c_cnt_w   = 4;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    XFER = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_mux8_arbiter_mux.sv
// +----------------------------------------------------------------------+
// | genericMux8x1 : plain 8:1 word multiplexer                            |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module genericMux8x1 #(
  parameter int n = 8
) (
  input  logic [n-1:0] y0,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] y2,
  input  logic [n-1:0] y3,
  input  logic [n-1:0] y4,
  input  logic [n-1:0] y5,
  input  logic [n-1:0] y6,
  input  logic [n-1:0] y7,
  input  logic [2:0]   sel,
  output logic [n-1:0] f
);

  always_comb begin
    f = y0;
    case (sel)
      3'd0: f = y0;
      3'd1: f = y1;
      3'd2: f = y2;
      3'd3: f = y3;
      3'd4: f = y4;
      3'd5: f = y5;
      3'd6: f = y6;
      3'd7: f = y7;
      default: f = y0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux8_arbiter.sv
// +----------------------------------------------------------------------+
// | rr_mux8_arbiter : round-robin arbiter sharing one 8:1 mux, bounded    |
// | bursts, valid/ready output with per-requester ack. rev 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_mux8_arbiter
  import rr_mux8_arbiter_pkg::*;
#(
  parameter int n         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [c_num_req-1:0]   req,
  input  logic [c_num_req*n-1:0] din,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [n-1:0]           out_data,
  output logic [c_sel_w-1:0]     sel,
  output logic [c_num_req-1:0]   grant,
  output logic [c_num_req-1:0]   ack
);

  state_t               r_state, w_state_nxt;
  logic [c_sel_w-1:0]   r_ptr,   w_ptr_nxt;
  logic [c_sel_w-1:0]   r_sel,   w_sel_nxt;
  logic [c_num_req-1:0] r_grant, w_grant_nxt;
  logic [c_cnt_w-1:0]   r_cnt,   w_cnt_nxt;
  logic [c_sel_w-1:0]   w_pick;
  logic                 w_hs;

  // First set bit of r scanning p, p+1, ... with 3-bit wrap.
  function automatic logic [c_sel_w-1:0] rr_pick(input logic [c_num_req-1:0] r,
                                                 input logic [c_sel_w-1:0]   p);
    logic [c_sel_w-1:0] idx;
    rr_pick = p;
    for (int k = c_num_req - 1; k >= 0; k--) begin
      idx = p + c_sel_w'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign w_pick    = rr_pick(req, r_ptr);
  assign out_valid = (r_state == XFER) && req[r_sel];
  // A word presented while reset is asserted is never acknowledged.
  assign w_hs      = out_valid && out_ready && !reset;
  assign ack       = w_hs ? r_grant : '0;
  assign sel       = r_sel;
  assign grant     = r_grant;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ARB: begin
        if (|req) begin
          w_sel_nxt   = w_pick;
          w_grant_nxt = c_num_req'(1) << w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (!req[r_sel]) begin
          w_state_nxt = ARB;
          w_grant_nxt = '0;
          w_ptr_nxt   = r_sel + c_sel_w'(1);
        end else if (w_hs) begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
          if (r_cnt + c_cnt_w'(1) == c_cnt_w'(MAX_BURST)) begin
            w_state_nxt = ARB;
            w_grant_nxt = '0;
            w_ptr_nxt   = r_sel + c_sel_w'(1);
          end
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  genericMux8x1 #(
    .n (n)
  ) u_mux (
    .y0  (din[0*n +: n]),
    .y1  (din[1*n +: n]),
    .y2  (din[2*n +: n]),
    .y3  (din[3*n +: n]),
    .y4  (din[4*n +: n]),
    .y5  (din[5*n +: n]),
    .y6  (din[6*n +: n]),
    .y7  (din[7*n +: n]),
    .sel (r_sel),
    .f   (out_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_rr_mux8_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_rr_mux8_arbiter : scenario tasks plus randomized traffic against   |
// | a transaction-level arbitration model. rev 1.0                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rr_mux8_arbiter;

  localparam int N  = 8;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   req;
  logic [8*N-1:0] din;
  logic         out_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic [2:0]   sel;
  logic [7:0]   grant;
  logic [7:0]   ack;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: who owns the mux (-1 = nobody), beats delivered, rotation start, last grantee.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  int m_sel   = 0;

  rr_mux8_arbiter #(.n(N), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .din       (din),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .grant     (grant),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] e_grant();
    return (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
  endfunction

  function automatic logic e_valid();
    if (m_owner < 0) return 1'b0;
    return req[m_owner];
  endfunction

  function automatic logic [7:0] e_ack();
    return (e_valid() && out_ready && !reset) ? e_grant() : 8'h00;
  endfunction

  function automatic logic [N-1:0] e_data();
    return din[m_owner*N +: N];
  endfunction

  // Advance one clock; the model consumes the inputs seen at the edge.
  task automatic step();
    bit found;
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_beats = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < 8; k++) begin
        if (!found && req[(m_ptr + k) % 8]) begin
          found   = 1;
          m_owner = (m_ptr + k) % 8;
        end
      end
      if (found) begin
        m_sel   = m_owner;
        m_beats = 0;
      end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (out_ready) begin
      m_beats++;
      if (m_beats == MB) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end
    end
    #1;
  endtask

  task automatic go_idle();
    req = 8'h00;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 8'h00; out_ready = 1'b0; din = '0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({grant, ack, sel, out_valid} !== {8'h00, 8'h00, 3'd0, 1'b0}) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got g=%h a=%h s=%0d v=%b want all zero",
                 cyc, grant, ack, sel, out_valid);
      end
      step();
    end
  endtask

  task automatic test_single();
    int acks = 0;
    req = 8'h04; out_ready = 1'b1;
    din = {$urandom, $urandom};
    din[2*N +: N] = 8'hA5;
    for (int i = 0; i < 12; i++) begin
      #1;
      total++;
      if ({grant, ack, sel, out_valid} !== {e_grant(), e_ack(), m_sel[2:0], e_valid()}) begin
        bad++;
        $display("FAIL single cyc=%0d got g=%h a=%h s=%0d v=%b want g=%h a=%h s=%0d v=%b",
                 cyc, grant, ack, sel, out_valid, e_grant(), e_ack(), m_sel[2:0], e_valid());
      end
      if (e_valid()) begin
        total++;
        if (out_data !== 8'hA5) begin
          bad++;
          $display("FAIL single_data cyc=%0d got %h want a5", cyc, out_data);
        end
      end
      if (i == 1) begin
        total++;
        if (grant !== 8'h04 || sel !== 3'd2) begin
          bad++;
          $display("FAIL single_latency got g=%h s=%0d want g=04 s=2", grant, sel);
        end
      end
      if (i >= 1 && i <= 5 && ack[2]) acks++;
      step();
    end
    total++;
    if (acks != 4) begin
      bad++;
      $display("FAIL single_burst got %0d acks want 4", acks);
    end
    go_idle();
  endtask

  task automatic test_rotation();
    logic [7:0] order[$];
    logic [7:0] prev = 8'h00;
    reset = 1'b1; step(); reset = 1'b0;
    req = 8'h81; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      din = {$urandom, $urandom};
      #1;
      total++;
      if ({grant, ack, sel, out_valid} !== {e_grant(), e_ack(), m_sel[2:0], e_valid()}) begin
        bad++;
        $display("FAIL rotation cyc=%0d got g=%h a=%h s=%0d v=%b want g=%h a=%h s=%0d v=%b",
                 cyc, grant, ack, sel, out_valid, e_grant(), e_ack(), m_sel[2:0], e_valid());
      end
      if (e_valid()) begin
        total++;
        if (out_data !== e_data()) begin
          bad++;
          $display("FAIL rotation_data cyc=%0d got %h want %h", cyc, out_data, e_data());
        end
      end
      if (grant != 8'h00 && grant != prev) order.push_back(grant);
      prev = grant;
      step();
    end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (j >= order.size() || order[j] !== ((j % 2 == 0) ? 8'h01 : 8'h80)) begin
        bad++;
        $display("FAIL rotation_order idx=%0d got %h want %h", j,
                 (j < order.size()) ? order[j] : 8'hxx, (j % 2 == 0) ? 8'h01 : 8'h80);
      end
    end
    go_idle();
  endtask

  task automatic test_backpressure();
    int acks_hold = 0;
    int acks_go = 0;
    req = 8'h10; out_ready = 1'b0;
    din = {$urandom, $urandom};
    for (int i = 0; i < 20; i++) begin
      out_ready = (i >= 11);
      #1;
      total++;
      if ({grant, ack, sel, out_valid} !== {e_grant(), e_ack(), m_sel[2:0], e_valid()}) begin
        bad++;
        $display("FAIL backpressure cyc=%0d got g=%h a=%h s=%0d v=%b want g=%h a=%h s=%0d v=%b",
                 cyc, grant, ack, sel, out_valid, e_grant(), e_ack(), m_sel[2:0], e_valid());
      end
      if (i >= 1 && i <= 10) begin
        if (ack != 8'h00) acks_hold++;
        total++;
        if (grant !== 8'h10 || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL backpressure_hold cyc=%0d got g=%h v=%b want g=10 v=1", cyc, grant, out_valid);
        end
      end
      if (i >= 11 && i <= 15 && ack[4]) acks_go++;
      step();
    end
    total++;
    if (acks_hold != 0 || acks_go != 4) begin
      bad++;
      $display("FAIL backpressure_acks got hold=%0d go=%0d want hold=0 go=4", acks_hold, acks_go);
    end
    go_idle();
  endtask

  task automatic test_early_drop();
    int acks5 = 0;
    bit saw6 = 0;
    reset = 1'b1; step(); reset = 1'b0;
    out_ready = 1'b1;
    din = {$urandom, $urandom};
    for (int i = 0; i < 14; i++) begin
      req = (acks5 >= 2) ? 8'h40 : 8'h60;
      #1;
      total++;
      if ({grant, ack, sel, out_valid} !== {e_grant(), e_ack(), m_sel[2:0], e_valid()}) begin
        bad++;
        $display("FAIL early_drop cyc=%0d got g=%h a=%h s=%0d v=%b want g=%h a=%h s=%0d v=%b",
                 cyc, grant, ack, sel, out_valid, e_grant(), e_ack(), m_sel[2:0], e_valid());
      end
      if (e_ack() == 8'h20) acks5++;
      if (grant == 8'h40) saw6 = 1;
      step();
    end
    total++;
    if (!saw6) begin
      bad++;
      $display("FAIL early_drop_next got no grant to 6 want grant=40");
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    bit pulsed = 0;
    reset = 1'b1; step(); reset = 1'b0;
    req = 8'h08; out_ready = 1'b1;
    din = {$urandom, $urandom};
    for (int i = 0; i < 14; i++) begin
      reset = (!pulsed && m_owner == 3 && m_beats == 1);
      #1;
      total++;
      if ({grant, ack, sel, out_valid} !== {e_grant(), e_ack(), m_sel[2:0], e_valid()}) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d got g=%h a=%h s=%0d v=%b want g=%h a=%h s=%0d v=%b",
                 cyc, grant, ack, sel, out_valid, e_grant(), e_ack(), m_sel[2:0], e_valid());
      end
      if (reset) begin
        pulsed = 1;
        step();
        reset = 1'b0;
        #1;
        total++;
        if (grant !== 8'h00 || ack !== 8'h00 || sel !== 3'd0) begin
          bad++;
          $display("FAIL reset_mid_abort got g=%h a=%h s=%0d want 0", grant, ack, sel);
        end
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_random();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 63) == 0);
      din = {$urandom, $urandom};
      #1;
      total++;
      if ({grant, ack, sel, out_valid} !== {e_grant(), e_ack(), m_sel[2:0], e_valid()}) begin
        bad++;
        $display("FAIL random cyc=%0d got g=%h a=%h s=%0d v=%b want g=%h a=%h s=%0d v=%b",
                 cyc, grant, ack, sel, out_valid, e_grant(), e_ack(), m_sel[2:0], e_valid());
      end
      if (e_valid()) begin
        total++;
        if (out_data !== e_data()) begin
          bad++;
          $display("FAIL random_data cyc=%0d got %h want %h", cyc, out_data, e_data());
        end
      end
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_early_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
